icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised successor to the team's 2-way, 256-set, 8-word-line instruction cache. Same fetch-side and memory-side contract.
- Generalisations:
  - configurable way count, set count and line length;
  - per-set round-robin replacement;
  - uncached bypass fetch;
  - handshake on the memory read request;
  - whole-cache invalidate by sweeping the sets.
- Sits between IF stage and AXI bridge. Tag+valid and data held in synchronous-read RAMs (one read port, one write port per way).

Parameters:
WAYS, 2, number of ways; power of 2, 1..8
SETS, 256, number of sets; power of 2, 16..1024
LINE_WORDS, 8, 32-bit words per line; power of 2, 2..16
Derived: OFF_W=log2(LINE_WORDS)+2, IDX_W=log2(SETS), TAG_W=32-IDX_W-OFF_W; index=addr[OFF_W+IDX_W-1:OFF_W], word select=addr[OFF_W-1:2].

Ports:
clk  in  1  clock
rst_n  in  1  one clock; reset is synchronous and active-low
cpu_icache_en  in  1  fetch request, accepted when icache_free=1
physical_addr  in  32  fetch address, word aligned, sampled at accept
uncached  in  1  bypass cache for this fetch, sampled at accept
icache_flush_en  in  1  invalidate all lines, accepted when icache_free=1
icache_free  out  1  IDLE, able to accept
icache_hit  out  1  one-cycle pulse, response came from a hit
icache_cpu_data  out  32  instruction word
icache_cpu_data_en  out  1  one-cycle pulse, icache_cpu_data valid
cache_mem_read_en  out  1  memory read request, held until ready
cache_mem_read_addr  out  32  line-aligned address (cached) or word address (uncached)
cache_mem_read_uncached  out  1  request is single-word uncached
mem_icache_read_ready  in  1  bridge accepts request this cycle
mem_icache_return_en  in  1  return data valid, one-cycle pulse
mem_icache_return_data  in  32*LINE_WORDS  line; word i in bits [32i+31:32i]; uncached uses word 0

Behaviour:
- States: RESET_SWEEP, IDLE, LOOKUP, MISS, REFILL, FLUSH.
- rst_n=0 at a clock edge:
  - state goes to RESET_SWEEP and the sweep counter to 0;
  - all outputs 0; round-robin pointers 0;
  - any in-flight fetch is discarded.
- RESET_SWEEP/FLUSH: writes valid=0 to set[counter] in all ways, one set per cycle; the counter increments.
  - After the set SETS-1 write, the next state is IDLE.
  - Duration is exactly SETS cycles with icache_free=0.
  - FLUSH also zeroes the round-robin pointers.
- IDLE:
  - icache_flush_en has priority over cpu_icache_en and goes to FLUSH.
  - cpu_icache_en with uncached=0: latch addr; RAM read issued on index of physical_addr in the same cycle; go to LOOKUP.
  - cpu_icache_en with uncached=1: go to MISS.
- LOOKUP: compare the latched tag against all ways.
  - Hit: icache_hit=1, icache_cpu_data_en=1, data = hit way's selected word; go to IDLE. Hit latency is 1 cycle after accept.
  - Multi-way hit cannot occur. The lowest way wins if it does.
  - Miss: go to MISS.
- MISS: assert cache_mem_read_en with the address.
  - Cached address: {tag,index,OFF_W'b0}. Uncached address: the latched address.
  - Address and uncached flag are held stable until mem_icache_read_ready=1, then go to REFILL.
  - cache_mem_read_en is deasserted in REFILL.
- REFILL: wait for mem_icache_return_en. In that cycle:
  - icache_cpu_data_en=1 and icache_hit=0. Data = selected word, or word 0 if uncached (forwarded combinationally).
  - Cached only: write the whole line and {valid=1,tag} into way rr_ptr[index]. rr_ptr[index] increments modulo WAYS.
  - Go to IDLE.
- mem_icache_return_en outside REFILL is ignored. cpu_icache_en and icache_flush_en outside IDLE are ignored; the requester must hold or retry.
- Refill completes into IDLE, so the next accept sees the updated RAM: write and read in the same cycle are never needed.
- WAYS=1: rr_ptr is constant 0.

Test Plan:
1. Reset with rst_n low 3 cycles then high -> icache_free=0 for exactly 256 cycles, then 1; all other outputs 0 throughout.
2. Fetch 0x1C000104 after reset -> LOOKUP miss; read_en=1 with addr 0x1C000100, uncached=0. Return a line with word1=0x02800C0C -> data_en=1, data=0x02800C0C, hit=0. Refetch 0x1C000104 -> data_en and hit 1 cycle after accept, data=0x02800C0C.
3. Fetch 0x1C000100, 0x1C002100, 0x1C004100 (same index 0x08, WAYS=2) -> all miss. The third replaces the first (way0). Refetch 0x1C002100 hits; refetch 0x1C000100 misses.
4. Uncached fetch 0xBFC00008 -> read_addr 0xBFC00008, read_uncached=1, data=word0 of return. Refetch -> misses again; no RAM write.
5. Hold mem_icache_read_ready=0 for 5 cycles during MISS -> read_en and read_addr held constant. Assert a stray return_en during MISS -> ignored, no data_en.
6. After test 2, assert icache_flush_en and cpu_icache_en together -> FLUSH wins, icache_free=0 for 256 cycles. Refetch 0x1C000104 -> miss. rst_n=0 during REFILL -> no data_en; a late return_en is ignored.

Source files
------------

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative instruction cache with per-set round-robin replacement,
// uncached bypass, handshaked line requests and a set-sweeping invalidate.
module icache_nway #(
   parameter int WAYS       = 2,
   parameter int SETS       = 256,
   parameter int LINE_WORDS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cpu_icache_en,
   input  logic [31:0]              physical_addr,
   input  logic                     uncached,
   input  logic                     icache_flush_en,
   output logic                     icache_free,
   output logic                     icache_hit,
   output logic [31:0]              icache_cpu_data,
   output logic                     icache_cpu_data_en,
   output logic                     cache_mem_read_en,
   output logic [31:0]              cache_mem_read_addr,
   output logic                     cache_mem_read_uncached,
   input  logic                     mem_icache_read_ready,
   input  logic                     mem_icache_return_en,
   input  logic [32*LINE_WORDS-1:0] mem_icache_return_data
);
   localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 32 - IDX_W - OFF_W;
   localparam int WS_W   = OFF_W - 2;
   localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int LINE_W = 32 * LINE_WORDS;

   typedef enum logic [2:0] {
      S_RESET_SWEEP, S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  sweep_q, sweep_d;
   logic [31:0]       addr_q, addr_d;
   logic              unc_q, unc_d;
   logic [RR_W-1:0]   rr_q [SETS];
   logic [RR_W-1:0]   rr_d [SETS];

   // Tag RAM entries are {valid, tag}; RAM contents are not reset, the sweep clears them.
   logic [TAG_W:0]    tag_ram  [WAYS][SETS];
   logic [LINE_W-1:0] data_ram [WAYS][SETS];
   logic [TAG_W:0]    tag_dout  [WAYS];
   logic [LINE_W-1:0] data_dout [WAYS];

   logic [IDX_W-1:0]  addr_idx, req_idx;
   logic [TAG_W-1:0]  addr_tag;
   logic [WS_W-1:0]   addr_wsel;
   logic [RR_W-1:0]   victim, hit_way;
   logic              hit, rd_en, line_we, sweep_we;

   assign addr_idx  = addr_q[OFF_W+IDX_W-1:OFF_W];
   assign addr_tag  = addr_q[31:OFF_W+IDX_W];
   assign addr_wsel = addr_q[OFF_W-1:2];
   assign req_idx   = physical_addr[OFF_W+IDX_W-1:OFF_W];
   assign victim    = (WAYS > 1) ? rr_q[addr_idx] : '0;
   assign rd_en     = (state_q == S_IDLE) && !icache_flush_en && cpu_icache_en && !uncached;
   assign sweep_we  = (state_q == S_RESET_SWEEP) || (state_q == S_FLUSH);
   // A return arriving on the same edge as reset belongs to a discarded fetch.
   assign line_we   = rst_n && (state_q == S_REFILL) && mem_icache_return_en && !unc_q;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (tag_dout[w] == {1'b1, addr_tag}) begin
            hit     = 1'b1;
            hit_way = RR_W'(w);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (sweep_we) begin
            tag_ram[w][sweep_q] <= '0;
         end else if (line_we && victim == RR_W'(w)) begin
            tag_ram[w][addr_idx]  <= {1'b1, addr_tag};
            data_ram[w][addr_idx] <= mem_icache_return_data;
         end
         if (rd_en) begin
            tag_dout[w]  <= tag_ram[w][req_idx];
            data_dout[w] <= data_ram[w][req_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RESET_SWEEP;
         sweep_q <= '0;
         addr_q  <= '0;
         unc_q   <= 1'b0;
         rr_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         addr_q  <= addr_d;
         unc_q   <= unc_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      addr_d  = addr_q;
      unc_d   = unc_q;
      rr_d    = rr_q;
      case (state_q)
         S_RESET_SWEEP, S_FLUSH: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (icache_flush_en) begin
               state_d = S_FLUSH;
               sweep_d = '0;
               rr_d    = '{default: '0};
            end else if (cpu_icache_en) begin
               addr_d  = physical_addr;
               unc_d   = uncached;
               state_d = uncached ? S_MISS : S_LOOKUP;
            end
         end
         S_LOOKUP: state_d = hit ? S_IDLE : S_MISS;
         S_MISS:   if (mem_icache_read_ready) state_d = S_REFILL;
         S_REFILL: begin
            if (mem_icache_return_en) begin
               state_d = S_IDLE;
               if (!unc_q && WAYS > 1) rr_d[addr_idx] = victim + 1'b1;
            end
         end
         default:  state_d = S_RESET_SWEEP;
      endcase
   end

   always_comb begin
      icache_free             = 1'b0;
      icache_hit              = 1'b0;
      icache_cpu_data         = '0;
      icache_cpu_data_en      = 1'b0;
      cache_mem_read_en       = 1'b0;
      cache_mem_read_addr     = '0;
      cache_mem_read_uncached = 1'b0;
      case (state_q)
         S_IDLE: icache_free = 1'b1;
         S_LOOKUP: begin
            if (hit) begin
               icache_hit         = 1'b1;
               icache_cpu_data_en = 1'b1;
               icache_cpu_data    = data_dout[hit_way][{addr_wsel, 5'b0} +: 32];
            end
         end
         S_MISS: begin
            cache_mem_read_en       = 1'b1;
            cache_mem_read_uncached = unc_q;
            cache_mem_read_addr     = unc_q ? addr_q : {addr_q[31:OFF_W], {OFF_W{1'b0}}};
         end
         S_REFILL: begin
            if (mem_icache_return_en) begin
               icache_cpu_data_en = 1'b1;
               icache_cpu_data    = unc_q ? mem_icache_return_data[31:0]
                                          : mem_icache_return_data[{addr_wsel, 5'b0} +: 32];
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - scoreboard bench for icache_nway at WAYS=2, SETS=256, LINE_WORDS=8.
module tb_icache_nway;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cpu_icache_en = 1'b0;
   logic [31:0]  physical_addr = '0;
   logic         uncached = 1'b0;
   logic         icache_flush_en = 1'b0;
   logic         icache_free, icache_hit, icache_cpu_data_en;
   logic [31:0]  icache_cpu_data;
   logic         cache_mem_read_en, cache_mem_read_uncached;
   logic [31:0]  cache_mem_read_addr;
   logic         mem_icache_read_ready = 1'b0;
   logic         mem_icache_return_en = 1'b0;
   logic [255:0] mem_icache_return_data = '0;

   typedef struct {
      logic [31:0] data;
      logic        hit;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   icache_nway #(.WAYS(2), .SETS(256), .LINE_WORDS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_icache_en(cpu_icache_en), .physical_addr(physical_addr), .uncached(uncached),
      .icache_flush_en(icache_flush_en), .icache_free(icache_free), .icache_hit(icache_hit),
      .icache_cpu_data(icache_cpu_data), .icache_cpu_data_en(icache_cpu_data_en),
      .cache_mem_read_en(cache_mem_read_en), .cache_mem_read_addr(cache_mem_read_addr),
      .cache_mem_read_uncached(cache_mem_read_uncached),
      .mem_icache_read_ready(mem_icache_read_ready), .mem_icache_return_en(mem_icache_return_en),
      .mem_icache_return_data(mem_icache_return_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h1C000104) return 32'h02800C0C;
      return a ^ 32'h5EED1234 ^ {a[15:0], a[31:16]};
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word(base + 32'(4*i));
      return l;
   endfunction

   task automatic wait_free();
      int n = 0;
      while (!icache_free && n < 2000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (icache_free !== 1'b1) begin
         $display("FAIL free_timeout got=%b exp=1", icache_free);
         miscompares++;
      end
   endtask

   task automatic fetch(input logic [31:0] a, input logic unc, input logic exp_hit,
                        input int delay, input logic stray);
      exp_t        e;
      int          n;
      logic [31:0] exp_ra;
      wait_free();
      cpu_icache_en = 1'b1;
      physical_addr = a;
      uncached      = unc;
      e.data = mem_word(a);
      e.hit  = exp_hit;
      sb.push_back(e);
      @(negedge clk);
      cpu_icache_en = 1'b0;
      uncached      = 1'b0;
      if (!exp_hit) begin
         exp_ra = unc ? a : {a[31:5], 5'b0};
         n = 0;
         while (!cache_mem_read_en && n < 4) begin
            @(negedge clk);
            n++;
         end
         vectors++;
         if (cache_mem_read_en !== 1'b1 || cache_mem_read_addr !== exp_ra
             || cache_mem_read_uncached !== unc) begin
            $display("FAIL miss_req got en=%b addr=%h unc=%b exp en=1 addr=%h unc=%b",
                     cache_mem_read_en, cache_mem_read_addr, cache_mem_read_uncached, exp_ra, unc);
            miscompares++;
         end
         for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            mem_icache_return_en = 1'b0;
            if (stray && i == 1) begin
               mem_icache_return_en   = 1'b1;
               mem_icache_return_data = line_of(exp_ra);
               #1;
               vectors++;
               if (icache_cpu_data_en !== 1'b0) begin
                  $display("FAIL stray_return got data_en=%b exp=0", icache_cpu_data_en);
                  miscompares++;
               end
            end
            vectors++;
            if (cache_mem_read_en !== 1'b1 || cache_mem_read_addr !== exp_ra) begin
               $display("FAIL req_held got en=%b addr=%h exp en=1 addr=%h",
                        cache_mem_read_en, cache_mem_read_addr, exp_ra);
               miscompares++;
            end
         end
         mem_icache_return_en  = 1'b0;
         mem_icache_read_ready = 1'b1;
         @(negedge clk);
         mem_icache_read_ready = 1'b0;
         vectors++;
         if (cache_mem_read_en !== 1'b0) begin
            $display("FAIL req_drop got en=%b exp=0", cache_mem_read_en);
            miscompares++;
         end
         mem_icache_return_en   = 1'b1;
         mem_icache_return_data = line_of(exp_ra);
         #1;
      end
      vectors++;
      if (icache_cpu_data_en !== 1'b1) begin
         $display("FAIL resp_missing addr=%h got data_en=%b exp=1", a, icache_cpu_data_en);
         miscompares++;
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (icache_cpu_data !== e.data || icache_hit !== e.hit) begin
            $display("FAIL resp addr=%h got data=%h hit=%b exp data=%h hit=%b",
                     a, icache_cpu_data, icache_hit, e.data, e.hit);
            miscompares++;
         end
      end
      if (!exp_hit) begin
         @(negedge clk);
         mem_icache_return_en = 1'b0;
      end
   endtask

   task automatic test_reset();
      int n = 0;
      int bad = 0;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if ({icache_free, icache_hit, icache_cpu_data_en, cache_mem_read_en,
              cache_mem_read_uncached} !== 5'b0 || icache_cpu_data !== '0
             || cache_mem_read_addr !== '0) begin
            $display("FAIL reset_outputs got free=%b hit=%b den=%b ren=%b exp all 0",
                     icache_free, icache_hit, icache_cpu_data_en, cache_mem_read_en);
            miscompares++;
         end
      end
      rst_n = 1'b1;
      while (!icache_free && n < 1000) begin
         if (icache_hit || icache_cpu_data_en || cache_mem_read_en || cache_mem_read_uncached
             || icache_cpu_data != 0 || cache_mem_read_addr != 0) bad++;
         n++;
         @(negedge clk);
      end
      vectors++;
      if (n !== 256 || bad !== 0) begin
         $display("FAIL reset_sweep got busy=%0d bad=%0d exp busy=256 bad=0", n, bad);
         miscompares++;
      end
   endtask

   task automatic test_fetch_hit();
      fetch(32'h1C000104, 1'b0, 1'b0, 0, 1'b0);
      fetch(32'h1C000104, 1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_flush();
      int n = 0;
      int bad = 0;
      wait_free();
      icache_flush_en = 1'b1;
      cpu_icache_en   = 1'b1;
      physical_addr   = 32'h1C000104;
      @(negedge clk);
      icache_flush_en = 1'b0;
      cpu_icache_en   = 1'b0;
      while (!icache_free && n < 1000) begin
         if (icache_cpu_data_en || cache_mem_read_en) bad++;
         n++;
         @(negedge clk);
      end
      vectors++;
      if (n !== 256 || bad !== 0) begin
         $display("FAIL flush_sweep got busy=%0d bad=%0d exp busy=256 bad=0", n, bad);
         miscompares++;
      end
      fetch(32'h1C000104, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_in_refill();
      wait_free();
      cpu_icache_en = 1'b1;
      physical_addr = 32'h1C008040;
      @(negedge clk);
      cpu_icache_en = 1'b0;
      @(negedge clk);
      vectors++;
      if (cache_mem_read_en !== 1'b1) begin
         $display("FAIL rir_req got en=%b exp=1", cache_mem_read_en);
         miscompares++;
      end
      mem_icache_read_ready = 1'b1;
      @(negedge clk);
      mem_icache_read_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      mem_icache_return_en   = 1'b1;
      mem_icache_return_data = line_of(32'h1C008040);
      #1;
      vectors++;
      if (icache_cpu_data_en !== 1'b0 || icache_free !== 1'b0) begin
         $display("FAIL rir_late_return got data_en=%b free=%b exp 0 0",
                  icache_cpu_data_en, icache_free);
         miscompares++;
      end
      @(negedge clk);
      mem_icache_return_en = 1'b0;
      rst_n = 1'b1;
      fetch(32'h1C008040, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_replacement();
      fetch(32'h1C000100, 1'b0, 1'b0, 0, 1'b0);
      fetch(32'h1C002100, 1'b0, 1'b0, 0, 1'b0);
      fetch(32'h1C004100, 1'b0, 1'b0, 0, 1'b0);
      fetch(32'h1C002100, 1'b0, 1'b1, 0, 1'b0);
      fetch(32'h1C000100, 1'b0, 1'b0, 0, 1'b0);
      fetch(32'h1C004100, 1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_uncached();
      fetch(32'hBFC00008, 1'b1, 1'b0, 0, 1'b0);
      fetch(32'hBFC00008, 1'b1, 1'b0, 0, 1'b0);
      fetch(32'hBFC00008, 1'b0, 1'b0, 0, 1'b0);
      fetch(32'hBFC00008, 1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_miss_hold();
      fetch(32'h1C010208, 1'b0, 1'b0, 5, 1'b1);
      fetch(32'h1C01021C, 1'b0, 1'b1, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fetch_hit();
      test_flush();
      test_reset_in_refill();
      test_replacement();
      test_uncached();
      test_miss_hold();
      vectors++;
      if (sb.size() !== 0) begin
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
